// File: rtl/key_pkg.sv
// Shared defaults and sizing helper for the push-button debouncer.
// Auto-repeat is compiled in only when KEY_AUTOREPEAT_EN is defined.
package key_pkg;

    localparam int KEY_W               = 4;
    localparam int KEY_DEBOUNCE_CYCLES = 1000000;  // 20 ms at 50 MHz
    localparam int KEY_REPEAT_DELAY    = 25000000;
    localparam int KEY_REPEAT_PERIOD   = 5000000;

    // Bits needed to hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key channel: 2-flop synchronizer, stable-level counter, press/release strobes.
// KEY_AUTOREPEAT_EN adds a repeat timer that re-strobes key_press while held.
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_sw,
    output logic key_pressed,
    output logic key_press,
    output logic key_release
);

    localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic          accept;

    // Idle level of the raw pin is high, so the chain resets to "released".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else          sync <= {sync[0], key_sw};
    end

    assign s      = ~sync[1];
    assign accept = (s != key_pressed) && (cnt == CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
    localparam int             RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RW       = cnt_w(RMAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            key_pressed <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (s == key_pressed) begin
                cnt <= '0;
            end else if (accept) begin
                key_pressed <= s;
                cnt         <= '0;
                key_press   <= s;
                key_release <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
`ifdef KEY_AUTOREPEAT_EN
            // Timer restarts at acceptance; suppressed on the release edge so
            // a repeat can never coincide with key_release.
            if (!key_pressed || accept) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST)) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
                key_press <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Debounces the raw active-low key bus into clean held levels plus press/release strobes.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat press strobes.
module key_debouncer
    import key_pkg::*;
#(
    parameter int W               = KEY_W,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] key_sw,
    output logic [W-1:0] key_pressed,
    output logic [W-1:0] key_press,
    output logic [W-1:0] key_release
);

    for (genvar g = 0; g < W; g++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .key_sw     (key_sw[g]),
            .key_pressed(key_pressed[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Repeat expectations follow KEY_AUTOREPEAT_EN when the bench is built with it.
module tb_key_debouncer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] key_sw;
    logic [W-1:0] key_pressed;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;

    int n_tests = 0;
    int n_fail  = 0;

    key_debouncer #(
        .W              (W),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_sw     (key_sw),
        .key_pressed(key_pressed),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks edges 1..6 after a level change: the event lands exactly on edge 6.
    task automatic expect_accept(input string name, input logic [W-1:0] lvl_before,
                                 input logic [W-1:0] lvl_after, input logic [W-1:0] prs,
                                 input logic [W-1:0] rel);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (key_pressed !== ((k == 6) ? lvl_after : lvl_before) ||
                key_press   !== ((k == 6) ? prs : '0) ||
                key_release !== ((k == 6) ? rel : '0)) begin
                n_fail++;
                $display("FAIL %s edge %0d: pressed=%b press=%b release=%b want pressed=%b press=%b release=%b",
                         name, k, key_pressed, key_press, key_release,
                         (k == 6) ? lvl_after : lvl_before, (k == 6) ? prs : '0, (k == 6) ? rel : '0);
            end
        end
        step();
        n_tests++;
        if (key_press !== '0 || key_release !== '0 || key_pressed !== lvl_after) begin
            n_fail++;
            $display("FAIL %s after: pressed=%b press=%b release=%b want pressed=%b no strobes",
                     name, key_pressed, key_press, key_release, lvl_after);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_sw  = 4'b0000;
        repeat (3) step();
        n_tests++;
        if (key_pressed !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: pressed=%b press=%b release=%b want 0000",
                     key_pressed, key_press, key_release);
        end
        reset_n = 1'b1;
        expect_accept("reset_release_all_held", 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        key_sw = 4'b1111;
        expect_accept("release_all", 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    endtask

    task automatic test_clean_press();
        key_sw = 4'b1110;
        expect_accept("clean_press_k0", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        key_sw = 4'b1111;
        expect_accept("clean_release_k0", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            key_sw = ((c / 2) % 2 == 0) ? 4'b1101 : 4'b1111;
            step();
            n_tests++;
            if (key_pressed !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: pressed=%b press=%b release=%b want 0000",
                         c, key_pressed, key_press, key_release);
            end
        end
        key_sw = 4'b1101;
        expect_accept("bounce_settle_k1", 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        key_sw = 4'b1111;
        expect_accept("bounce_release_k1", 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    endtask

    task automatic test_glitch();
        key_sw = 4'b1011;
        repeat (3) step();
        key_sw = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            step();
            n_tests++;
            if (key_pressed !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: pressed=%b press=%b release=%b want 0000",
                         c, key_pressed, key_press, key_release);
            end
        end
    endtask

    task automatic test_reset_midcount();
        key_sw = 4'b0111;
        repeat (4) step();   // counter at 2 after edge 4; third counting edge next
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (key_pressed !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midcount_async: pressed=%b press=%b release=%b want 0000",
                     key_pressed, key_press, key_release);
        end
        repeat (2) step();
        reset_n = 1'b1;
        expect_accept("reset_midcount_reaccept_k3", 4'b0000, 4'b1000, 4'b1000, 4'b0000);
        key_sw = 4'b1111;
        expect_accept("reset_midcount_release_k3", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    endtask

    task automatic test_autorepeat();
        logic [W-1:0] exp_p;
        key_sw = 4'b1110;
        expect_accept("repeat_accept_k0", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        // expect_accept already consumed offset +1; continue from +2.
        for (int m = 2; m <= 30; m++) begin
            step();
`ifdef KEY_AUTOREPEAT_EN
            exp_p = (m >= 10 && ((m - 10) % 3) == 0) ? 4'b0001 : 4'b0000;
`else
            exp_p = 4'b0000;
`endif
            n_tests++;
            if (key_press !== exp_p || key_pressed !== 4'b0001 || key_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL repeat offset +%0d: press=%b pressed=%b release=%b want press=%b pressed=0001",
                         m, key_press, key_pressed, key_release, exp_p);
            end
        end
        key_sw = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (key_release !== ((k == 6) ? 4'b0001 : 4'b0000) ||
                key_pressed !== ((k == 6) ? 4'b0000 : 4'b0001)) begin
                n_fail++;
                $display("FAIL repeat_release edge %0d: pressed=%b release=%b",
                         k, key_pressed, key_release);
            end
        end
        repeat (15) begin
            step();
            n_tests++;
            if (key_press !== 4'b0000 || key_pressed !== 4'b0000) begin
                n_fail++;
                $display("FAIL repeat_after_release: press=%b pressed=%b want 0000",
                         key_press, key_pressed);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_sw = 4'b1010;
        expect_accept("simul_press_k0k2", 4'b0000, 4'b0101, 4'b0101, 4'b0000);
        key_sw = 4'b1111;
        expect_accept("simul_release_k0k2", 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_midcount();
        test_simultaneous();
        test_autorepeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
